dmem_responder: RTL and testbench

// - Tagged data-memory model: the responder end of the dcache<->memory command/tag/data protocol.
// - Accepts one MEM_LOAD/MEM_STORE per cycle and answers with a transaction tag in the same cycle.
// - Returns load data with a matching data tag exactly LATENCY cycles later.
// - Sits below dcache in the testbench/system top and backs the data-side miss and writeback traffic.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Tagged data-memory responder: same-cycle transaction tag, load data LATENCY cycles later, tag 0 = reject when full.
// Optional `DMEM_BOUNDS_CHECK_EN: out-of-range requests are rejected and flagged on dmem_error.
module dmem_responder #(
   parameter int NUM_TAGS  = 15,
   parameter int LATENCY   = 4,
   parameter int MEM_WORDS = 8192
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2Dmem_command,
   input  logic [31:0] proc2Dmem_addr,
   input  logic [63:0] proc2Dmem_data,
   output logic [3:0]  Dmem2proc_transaction_tag,
   output logic [63:0] Dmem2proc_data,
   output logic [3:0]  Dmem2proc_data_tag,
   output logic        dmem_error
);
   localparam logic [1:0] MEM_NONE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;
   localparam int         IDX_W     = $clog2(MEM_WORDS);
   localparam int         SLOT_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
   localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

   logic [63:0]         mem_q [MEM_WORDS];
   logic [NUM_TAGS-1:0] busy_q, busy_d;
   logic [NUM_TAGS-1:0] is_load_q, is_load_d;
   logic [3:0]          cnt_q [NUM_TAGS];
   logic [3:0]          cnt_d [NUM_TAGS];
   logic [63:0]         snap_q [NUM_TAGS];
   logic [63:0]         snap_d [NUM_TAGS];
   logic [3:0]          data_tag_q, data_tag_d;
   logic [63:0]         data_q, data_d;

   logic [IDX_W-1:0]    idx;
   logic [63:0]         rd_dat;
   logic                req_vld, ld_req, oob, accept, wr_en;
   logic                free_vld;
   logic [SLOT_W-1:0]   free_idx;
   logic                unused_addr;

   assign idx         = proc2Dmem_addr[3 +: IDX_W];
   assign rd_dat      = mem_q[idx];
   assign req_vld     = reset && (proc2Dmem_command != MEM_NONE);
   assign ld_req      = (proc2Dmem_command == MEM_LOAD);
   assign accept      = req_vld && free_vld && !oob;
   assign wr_en       = accept && (proc2Dmem_command == MEM_STORE);
   assign unused_addr = ^{proc2Dmem_addr[31:3+IDX_W], proc2Dmem_addr[2:0]};

   assign Dmem2proc_transaction_tag = accept ? (4'(free_idx) + 4'd1) : 4'd0;
   assign Dmem2proc_data_tag        = data_tag_q;
   assign Dmem2proc_data            = data_q;

   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_vld = 1'b1;
            free_idx = SLOT_W'(i);
         end
      end
   end

   // Fixed latency and one accept per cycle guarantee at most one expiry per edge.
   always_comb begin
      busy_d     = busy_q;
      is_load_d  = is_load_q;
      cnt_d      = cnt_q;
      snap_d     = snap_q;
      data_tag_d = '0;
      data_d     = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (busy_q[i]) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
            if (cnt_q[i] == 4'd1) begin
               busy_d[i] = 1'b0;
               if (is_load_q[i]) begin
                  data_tag_d = 4'(i + 1);
                  data_d     = snap_q[i];
               end
            end
         end
      end
      if (accept) begin
         if (LATENCY == 1) begin
            if (ld_req) begin
               data_tag_d = 4'(free_idx) + 4'd1;
               data_d     = rd_dat;
            end
         end else begin
            busy_d[free_idx]    = 1'b1;
            is_load_d[free_idx] = ld_req;
            cnt_d[free_idx]     = LAT_M1;
            snap_d[free_idx]    = rd_dat;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         busy_q     <= '0;
         data_tag_q <= '0;
         data_q     <= '0;
      end else begin
         busy_q     <= busy_d;
         data_tag_q <= data_tag_d;
         data_q     <= data_d;
      end
   end

   // Slot payload is only meaningful while busy, so it carries no reset.
   always_ff @(posedge clock) begin
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[idx] <= proc2Dmem_data;
   end

`ifdef DMEM_BOUNDS_CHECK_EN
   logic err_q, err_d;

   assign oob        = (proc2Dmem_addr[31:3] >= 29'(MEM_WORDS));
   assign dmem_error = err_q;

   always_comb begin
      err_d = req_vld && oob;
   end

   always_ff @(posedge clock) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`else
   assign oob        = 1'b0;
   assign dmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 15-tag and a 2-tag instance driven per cycle, returns checked against a scoreboard.
module tb_dmem_responder;
   localparam int         LAT     = 4;
   localparam logic [1:0] M_NONE  = 2'd0;
   localparam logic [1:0] M_LOAD  = 2'd1;
   localparam logic [1:0] M_STORE = 2'd2;

   typedef struct {
      int          k;
      int          due;
      logic [3:0]  tag;
      logic [63:0] dat;
      bit          chk_dat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0][1:0]  cmd;
   logic [1:0][31:0] addr;
   logic [1:0][63:0] wdat;
   logic [1:0][3:0]  tt;
   logic [1:0][3:0]  dtag;
   logic [1:0][63:0] rdat;
   logic [1:0]       err;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          busy_until [2][15];
   int          ntags [2] = '{15, 2};
   logic [63:0] mmem [2][8192];
   bit          known [2][8192];
   bit          err_pend [2];
   bit          mon_en = 1'b0;
   exp_t        sbq [$];

   dmem_responder #(.NUM_TAGS(15), .LATENCY(LAT), .MEM_WORDS(8192)) u_dut0 (
      .clock(clk), .reset(rst_n),
      .proc2Dmem_command(cmd[0]), .proc2Dmem_addr(addr[0]), .proc2Dmem_data(wdat[0]),
      .Dmem2proc_transaction_tag(tt[0]), .Dmem2proc_data(rdat[0]),
      .Dmem2proc_data_tag(dtag[0]), .dmem_error(err[0])
   );

   dmem_responder #(.NUM_TAGS(2), .LATENCY(LAT), .MEM_WORDS(8192)) u_dut1 (
      .clock(clk), .reset(rst_n),
      .proc2Dmem_command(cmd[1]), .proc2Dmem_addr(addr[1]), .proc2Dmem_data(wdat[1]),
      .Dmem2proc_transaction_tag(tt[1]), .Dmem2proc_data(rdat[1]),
      .Dmem2proc_data_tag(dtag[1]), .dmem_error(err[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic issue(input int k, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
      cmd[k]  = c;
      addr[k] = a;
      wdat[k] = d;
   endtask

   task automatic monitor(input int k);
      logic [3:0]  etag;
      logic [63:0] edat;
      bit          cd;
      etag = '0;
      edat = '0;
      cd   = 1'b1;
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].k == k && sbq[i].due == cyc) begin
            etag = sbq[i].tag;
            edat = sbq[i].dat;
            cd   = sbq[i].chk_dat;
            sbq.delete(i);
            break;
         end
      end
      check($sformatf("data_tag%0d", k), 64'(dtag[k]), 64'(etag));
      if (cd) check($sformatf("data%0d", k), rdat[k], edat);
      check($sformatf("dmem_error%0d", k), 64'(err[k]), 64'(err_pend[k]));
   endtask

   task automatic eval(input int k);
      logic [3:0] etag;
      int         ix;
      bit         oob;
      etag = '0;
      ix   = int'(addr[k][15:3]);
      oob  = (addr[k][31:3] >= 29'd8192);
`ifndef DMEM_BOUNDS_CHECK_EN
      oob  = 1'b0;
`endif
      err_pend[k] = 1'b0;
      if (!rst_n) begin
         for (int s = 0; s < 15; s++) busy_until[k][s] = 0;
         for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].k == k && sbq[i].due > cyc) sbq.delete(i);
      end else if (cmd[k] != M_NONE) begin
         if (oob) begin
            err_pend[k] = 1'b1;
         end else begin
            for (int s = 0; s < ntags[k]; s++) begin
               if (busy_until[k][s] <= cyc) begin
                  etag = 4'(s + 1);
                  busy_until[k][s] = cyc + LAT;
                  if (cmd[k] == M_LOAD) begin
                     sbq.push_back('{k, cyc + LAT, etag, mmem[k][ix], known[k][ix]});
                  end else if (cmd[k] == M_STORE) begin
                     mmem[k][ix]  = wdat[k];
                     known[k][ix] = 1'b1;
                  end
                  break;
               end
            end
         end
      end
      check($sformatf("txn_tag%0d", k), 64'(tt[k]), 64'(etag));
   endtask

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (mon_en) monitor(k);
         eval(k);
      end
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      cmd  = '0;
      addr = '0;
      wdat = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd   = '0;
      addr  = '0;
      wdat  = '0;
      @(posedge clk);
      #1;
      // Requests during reset must be ignored.
      issue(0, M_LOAD, 32'h0, 64'h0); step();
      issue(1, M_LOAD, 32'h0, 64'h0); step();
      rst_n = 1'b1;
      issue(0, M_LOAD, 32'h0, 64'h0);
      issue(1, M_LOAD, 32'h0, 64'h0);
      step();
      repeat (6) step();

      for (int b = 0; b < 16; b++) begin
         issue(0, M_STORE, 32'(b * 8), {$urandom, $urandom});
         step();
      end
      repeat (5) step();

      issue(0, M_STORE, 32'h10, 64'hDEAD_BEEF_0123_4567); step();
      repeat (3) step();
      issue(0, M_LOAD, 32'h10, 64'h0); step();
      repeat (6) step();

      issue(0, M_STORE, 32'h18, 64'hA5);
      issue(1, M_STORE, 32'h18, 64'hA5);
      step();
      issue(0, M_LOAD, 32'h18, 64'h0);
      issue(1, M_LOAD, 32'h18, 64'h0);
      step();
      repeat (6) step();

      // Five back-to-back loads on the 2-tag instance: tags 1,2,0,0,1.
      for (int j = 0; j < 5; j++) begin
         issue(1, M_LOAD, 32'h18, 64'h0);
         issue(0, M_LOAD, 32'(j * 8), 64'h0);
         step();
      end
      repeat (6) step();

      for (int j = 0; j < 80; j++) begin
         for (int k = 0; k < 2; k++) begin
            issue(k, 2'($urandom_range(0, 2)),
                  32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7)), {$urandom, $urandom});
         end
         step();
      end
      repeat (6) step();

      issue(0, M_LOAD, 32'h10, 64'h0);
      issue(1, M_LOAD, 32'h18, 64'h0);
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (8) step();
      issue(0, M_LOAD, 32'h10, 64'h0);
      issue(1, M_LOAD, 32'h18, 64'h0);
      step();
      repeat (6) step();

      issue(0, M_LOAD, 32'h0001_0000, 64'h0);
      issue(1, M_STORE, 32'h8001_0008, 64'h1234_5678_9ABC_DEF0);
      step();
      repeat (4) step();
      issue(1, M_LOAD, 32'h8, 64'h0); step();
      repeat (6) step();

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
